event_packer: RTL and testbench
===============================

EVENT_PACKER -- requirements
Module: event_packer

Interface
REQ-001 Parameter NUM_UNITS, default 4, number of detector units; fixed at 4 in this revision (unit ID is 2 bits).
REQ-002 Parameter FIFO_DEPTH, default 8, packet FIFO depth; power of two, at least 2.
REQ-003 Parameter TS_WIDTH, default 11, timestamp width in bits.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 sample_valid  input  1  one-cycle frame strobe from the upstream processing_system.
REQ-007 spike_detection_array  input  NUM_UNITS  per-unit spike flags, valid while sample_valid is high.
REQ-008 event_out_array  input  2*NUM_UNITS  per-unit 2-bit event codes; unit k occupies bits [2k+1:2k].
REQ-009 evt_data  output  16  packet word at the FIFO head.
REQ-010 evt_valid  output  1  FIFO non-empty.
REQ-011 evt_ready  input  1  consumer accepts evt_data.
REQ-012 fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy.
REQ-013 overflow  output  1  sticky flag: a packet was lost because the FIFO was full.
REQ-014 frame_drop  output  1  sticky flag: a frame was lost because a scan was in progress.
REQ-015 clear_flags  input  1  synchronous clear of overflow and frame_drop.

Function
REQ-016 FSM states: IDLE and SCAN.
  - IDLE: sample_valid high -> capture both arrays into frame registers, reset unit index to 0, go to SCAN.
  - SCAN: examine one unit per cycle in index order 0..NUM_UNITS-1; return to IDLE after the last unit.
REQ-017 A unit qualifies when its spike bit is 1 or its event code is non-zero; a qualifying unit pushes exactly one packet, a non-qualifying unit pushes nothing.
REQ-018 Packet format:
  - [15] spike bit
  - [14:13] event code
  - [12:11] unit index
  - [10:0] timestamp latched at frame capture
REQ-019 Timestamp counter: increments by 1 on every sample_valid pulse, including dropped frames; wraps modulo 2^TS_WIDTH; a captured frame uses the counter value before that frame's increment.
REQ-020 sample_valid while in SCAN (including the last SCAN cycle): the frame is discarded and frame_drop is set.
REQ-021 FIFO behaviour:
  - First-word fall-through: evt_data presents the head entry combinationally from storage; evt_valid = (fifo_count != 0).
  - Pop when evt_valid and evt_ready are both high; evt_ready with an empty FIFO has no effect.
REQ-022 Push while full:
  - Without a pop in the same cycle: the packet is discarded and overflow is set.
  - With a pop in the same cycle: the push is accepted and fifo_count is unchanged.
REQ-023 Pointers wrap modulo FIFO_DEPTH.
REQ-024 Packet latency: a packet for unit k is visible on evt_data, with evt_valid high, k+2 cycles after the sample_valid cycle, provided the FIFO was empty.
REQ-025 clear_flags has priority over setting a flag in the same cycle: both flags read 0 on the following cycle.

Reset
REQ-026 rst low asynchronously forces:
  - FSM to IDLE, unit index 0
  - timestamp, FIFO pointers and fifo_count to 0
  - evt_valid, overflow and frame_drop to 0
REQ-027 evt_data after reset is don't-care while evt_valid is 0.
REQ-028 Reset asserted mid-scan abandons the scan; no partial packets survive.

Configuration
REQ-029 Macro EVENT_PACKER_TIMESTAMP_EN.
  - Defined: timestamp counter implemented; bits [10:0] carry the timestamp as in REQ-018.
  - Undefined: no counter logic; bits [10:0] are tied to 0; all other behaviour is identical.

Verification
REQ-030 Single frame: frame with spike=4'b0101, events=8'h00 at timestamp 0 -> two packets, 16'h8000 then 16'h9000; evt_ready held high; fifo_count returns to 0.
REQ-031 Event-only unit: unit 3 with event 2'b10, spike 0, at timestamp 5 -> one packet, 16'h5805.
REQ-032 Overflow: evt_ready held low, three frames each with all units qualifying -> fifo_count saturates at 8; overflow=1; the first 8 packets drain in order.
REQ-033 Frame drop: second sample_valid issued 2 cycles after the first -> frame_drop=1; no packets from the second frame; the next frame's timestamp is 2.
REQ-034 Full with simultaneous push/pop: FIFO at 8 entries, evt_ready=1 during a scan -> no overflow; fifo_count stays at 8.
REQ-035 Reset mid-scan: rst pulsed low during SCAN -> evt_valid=0 and fifo_count=0 immediately; the next frame is timestamped 0.

Source files
------------

// File: rtl/event_packer_if.sv
// event_packer_if -- packet stream between event_packer and its consumer.
//   evt_data  [15:0] packet word at the FIFO head (producer -> consumer)
//   evt_valid        FIFO non-empty                (producer -> consumer)
//   evt_ready        consumer accepts evt_data     (consumer -> producer)
// Modports: master = packer side, slave = consumer side.
`timescale 1ns/1ps
interface event_packer_if;
    logic [15:0] evt_data;
    logic        evt_valid;
    logic        evt_ready;

    modport master (output evt_data, output evt_valid, input evt_ready);
    modport slave  (input evt_data, input evt_valid, output evt_ready);
endinterface

// File: rtl/event_packer.sv
// event_packer -- captures a frame of per-unit spike flags / event codes on
// sample_valid, scans the units one per cycle and pushes a 16-bit packet for
// every qualifying unit into a first-word fall-through FIFO.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   sample_valid             frame strobe
//   spike_detection_array    per-unit spike flags
//   event_out_array          per-unit 2-bit event codes (unit k at [2k+1:2k])
//   evt                      packet stream (event_packer_if.master)
//   fifo_count               FIFO occupancy
//   overflow                 sticky: packet lost on a full FIFO
//   frame_drop               sticky: frame lost while a scan was running
//   clear_flags              synchronous clear of both sticky flags
//
// Packet: [15] spike, [14:13] event, [12:11] unit, [10:0] timestamp.
// Build option: define EVENT_PACKER_TIMESTAMP_EN to implement the frame
// timestamp counter; otherwise the timestamp field is tied to zero.
`timescale 1ns/1ps
module event_packer #(
    parameter int NUM_UNITS  = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int TS_WIDTH   = 11
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sample_valid,
    input  logic [NUM_UNITS-1:0]          spike_detection_array,
    input  logic [2*NUM_UNITS-1:0]        event_out_array,
    event_packer_if.master                evt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          frame_drop,
    input  logic                          clear_flags
);
    localparam int IDX_W = $clog2(NUM_UNITS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_UNITS - 1);

    typedef enum logic {IDLE, SCAN} state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    capture, drop, scanning;

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: if (sample_valid) begin
                state_d = SCAN;
                idx_d   = '0;
            end
            SCAN: if (idx_q == LAST_IDX) begin
                state_d = IDLE;
                idx_d   = '0;
            end else begin
                idx_d   = idx_q + 1'b1;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        capture  = (state_q == IDLE) && sample_valid;
        drop     = (state_q == SCAN) && sample_valid;
        scanning = (state_q == SCAN);
    end

    // ------------------------------------------------------------------
    // Frame registers
    // ------------------------------------------------------------------
    logic [NUM_UNITS-1:0]   spk_q, spk_d;
    logic [2*NUM_UNITS-1:0] ev_q, ev_d;

    always_comb begin
        spk_d = capture ? spike_detection_array : spk_q;
        ev_d  = capture ? event_out_array       : ev_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spk_q <= '0;
            ev_q  <= '0;
        end else begin
            spk_q <= spk_d;
            ev_q  <= ev_d;
        end
    end

    // ------------------------------------------------------------------
    // Timestamp
    // ------------------------------------------------------------------
    logic [10:0] ts_field;

`ifdef EVENT_PACKER_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_q, ts_d, ts_cap_q, ts_cap_d;

    // Counts every strobe, dropped frames included; a captured frame keeps
    // the pre-increment value.
    always_comb begin
        ts_d     = sample_valid ? ts_q + 1'b1 : ts_q;
        ts_cap_d = capture ? ts_q : ts_cap_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_q     <= '0;
            ts_cap_q <= '0;
        end else begin
            ts_q     <= ts_d;
            ts_cap_q <= ts_cap_d;
        end
    end

    if (TS_WIDTH >= 11) begin : g_ts_trunc
        assign ts_field = ts_cap_q[10:0];
    end else begin : g_ts_ext
        assign ts_field = {{(11-TS_WIDTH){1'b0}}, ts_cap_q};
    end
`else
    assign ts_field = '0;
`endif

    // ------------------------------------------------------------------
    // Unit select and packet build
    // ------------------------------------------------------------------
    logic        cur_spk;
    logic [1:0]  cur_ev;
    logic        push_req;
    logic [15:0] pkt;

    always_comb begin
        cur_spk = 1'b0;
        cur_ev  = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_spk = spk_q[k];
                cur_ev  = ev_q[2*k +: 2];
            end
        end
        push_req = scanning && (cur_spk || (cur_ev != 2'b00));
        pkt      = {cur_spk, cur_ev, idx_q, ts_field};
    end

    // ------------------------------------------------------------------
    // Packet FIFO (first-word fall-through)
    // ------------------------------------------------------------------
    logic [15:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full, pop, push, ovf_set;
    logic             overflow_q, overflow_d, frame_drop_q, frame_drop_d;

    always_comb begin
        full    = (count_q == CNT_W'(FIFO_DEPTH));
        pop     = (count_q != '0) && evt.evt_ready;
        // A full FIFO still accepts the push when the head leaves this cycle.
        push    = push_req && (!full || pop);
        ovf_set = push_req && full && !pop;

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Clear wins over a same-cycle set.
        overflow_d   = clear_flags ? 1'b0 : (overflow_q   | ovf_set);
        frame_drop_d = clear_flags ? 1'b0 : (frame_drop_q | drop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            frame_drop_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            frame_drop_q <= frame_drop_d;
        end
    end

    // Storage needs no reset: contents are only observed while count_q != 0.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= pkt;
    end

    assign evt.evt_data  = mem_q[rd_ptr_q];
    assign evt.evt_valid = (count_q != '0);
    assign fifo_count    = count_q;
    assign overflow      = overflow_q;
    assign frame_drop    = frame_drop_q;

endmodule

// File: tb/tb_event_packer.sv
// tb_event_packer -- directed + random test of event_packer against a
// transaction-level model (packet schedule per frame, FIFO as a queue).
`timescale 1ns/1ps
module tb_event_packer;
    localparam int NU    = 4;
    localparam int DEPTH = 8;
    localparam int TSW   = 11;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_valid;
    logic [3:0]  spike_detection_array;
    logic [7:0]  event_out_array;
    logic        clear_flags;
    logic [3:0]  fifo_count;
    logic        overflow;
    logic        frame_drop;

    event_packer_if ev_if();

    event_packer #(.NUM_UNITS(NU), .FIFO_DEPTH(DEPTH), .TS_WIDTH(TSW)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .sample_valid          (sample_valid),
        .spike_detection_array (spike_detection_array),
        .event_out_array       (event_out_array),
        .evt                   (ev_if),
        .fifo_count            (fifo_count),
        .overflow              (overflow),
        .frame_drop            (frame_drop),
        .clear_flags           (clear_flags)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    typedef struct { int cyc; logic [15:0] pkt; } pend_t;
    logic [15:0]    mq[$];
    pend_t          pend[$];
    int             cyc       = 0;
    int             scan_last = -1;
    logic [TSW-1:0] ts_m      = '0;
    bit             ovf_m     = 0;
    bit             fd_m      = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mk_pkt(input bit s, input logic [1:0] e, input int u,
                                           input logic [TSW-1:0] t);
        int tf;
`ifdef EVENT_PACKER_TIMESTAMP_EN
        tf = int'(t) % 2048;
`else
        tf = 0;
`endif
        return 16'(int'(s) * 32768 + int'(e) * 8192 + u * 2048 + tf);
    endfunction

    function automatic logic [15:0] exp_ts(input logic [15:0] base, input int t);
`ifdef EVENT_PACKER_TIMESTAMP_EN
        return base + 16'(t);
`else
        return base;
`endif
    endfunction

    task automatic check_outs();
        chk("evt_valid",  ev_if.evt_valid, 32'(mq.size() != 0));
        chk("fifo_count", fifo_count,      32'(mq.size()));
        if (mq.size() != 0) chk("evt_data", ev_if.evt_data, mq[0]);
        chk("overflow",   overflow,        32'(ovf_m));
        chk("frame_drop", frame_drop,      32'(fd_m));
    endtask

    // One clock cycle: drive inputs, advance the model, check after the edge.
    task automatic tick(input bit sv, input logic [3:0] sp, input logic [7:0] e,
                        input bit rdy, input bit clr);
        bit          pop, full, has_push;
        logic [15:0] p;
        sample_valid          = sv;
        spike_detection_array = sp;
        event_out_array       = e;
        ev_if.evt_ready       = rdy;
        clear_flags           = clr;

        pop      = (mq.size() != 0) && rdy;
        full     = (mq.size() == DEPTH);
        has_push = (pend.size() != 0) && (pend[0].cyc == cyc);
        p        = '0;
        if (has_push) begin
            p = pend[0].pkt;
            void'(pend.pop_front());
        end
        if (pop) void'(mq.pop_front());
        if (has_push) begin
            if (!full || pop) mq.push_back(p);
            else              ovf_m = 1;
        end
        if (sv) begin
            if (cyc <= scan_last) fd_m = 1;
            else begin
                for (int k = 0; k < NU; k++)
                    if (sp[k] || e[2*k +: 2] != 2'b00)
                        pend.push_back('{cyc + 1 + k, mk_pkt(sp[k], e[2*k +: 2], k, ts_m)});
                scan_last = cyc + NU;
            end
            ts_m = ts_m + 1'b1;
        end
        if (clr) begin ovf_m = 0; fd_m = 0; end

        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_outs();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) tick(0, 4'h0, 8'h00, rdy, 0);
    endtask

    // Asynchronous reset asserted between edges; outputs must drop at once.
    task automatic do_reset();
        sample_valid = 0; clear_flags = 0;
        rst = 1'b0;
        #1;
        mq.delete(); pend.delete();
        scan_last = -1; ts_m = '0; ovf_m = 0; fd_m = 0;
        chk("rst_valid", ev_if.evt_valid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ovf",   overflow, 0);
        chk("rst_fdrop", frame_drop, 0);
        @(posedge clk); cyc++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; sample_valid = 0; spike_detection_array = '0;
        event_out_array = '0; clear_flags = 0; ev_if.evt_ready = 0;
        repeat (2) @(negedge clk);
        chk("reset_valid", ev_if.evt_valid, 0);
        chk("reset_count", fifo_count, 0);
        chk("reset_ovf",   overflow, 0);
        chk("reset_fdrop", frame_drop, 0);
        rst = 1'b1;

        // Single frame, units 0 and 2 spiking, timestamp 0
        tick(1, 4'b0101, 8'h00, 1, 0);
        chk("single_cnt0", fifo_count, 0);
        tick(0, 4'h0, 8'h00, 1, 0);
        chk("single_pkt0", ev_if.evt_data, 16'h8000);
        tick(0, 4'h0, 8'h00, 1, 0);
        tick(0, 4'h0, 8'h00, 1, 0);
        chk("single_pkt2", ev_if.evt_data, 16'h9000);
        idle(2, 1);
        chk("single_cnt_end", fifo_count, 0);

        // Event-only unit 3 at timestamp 5 (four empty frames first)
        for (int f = 0; f < 4; f++) begin
            tick(1, 4'h0, 8'h00, 1, 0);
            idle(4, 1);
        end
        tick(1, 4'h0, 8'b1000_0000, 1, 0);
        idle(4, 1);
        chk("event_only_pkt", ev_if.evt_data, exp_ts(16'h5800, 5));
        idle(2, 1);

        // Frame drop: second strobe two cycles after the first
        do_reset();
        tick(1, 4'b0001, 8'h00, 1, 0);
        tick(0, 4'h0, 8'h00, 1, 0);
        tick(1, 4'b1111, 8'hFF, 1, 0);
        idle(4, 1);
        chk("fdrop_set", frame_drop, 1);
        tick(0, 4'h0, 8'h00, 1, 1);
        chk("fdrop_clear", frame_drop, 0);
        tick(1, 4'b0001, 8'h00, 1, 0);
        tick(0, 4'h0, 8'h00, 1, 0);
        chk("fdrop_next_ts", ev_if.evt_data, exp_ts(16'h8000, 2));
        idle(2, 1);
        tick(1, 4'b1111, 8'h00, 1, 0);      // strobe on the last scan cycle
        chk("fdrop_last_scan", frame_drop, 1);
        idle(3, 1);

        // Overflow: consumer stalled, three full frames
        tick(0, 4'h0, 8'h00, 1, 1);
        for (int f = 0; f < 3; f++) begin
            tick(1, 4'b1111, 8'h00 + 8'(f), 0, 0);
            for (int k = 0; k < NU; k++)
                tick(0, 4'h0, 8'h00, 0, (f == 2 && k == NU-1));  // clear beats last set
        end
        chk("ovf_cnt_sat", fifo_count, 8);
        chk("ovf_clear_prio", overflow, 0);
        tick(1, 4'b1111, 8'h00, 0, 0);
        idle(4, 0);
        chk("ovf_set", overflow, 1);
        chk("ovf_cnt_sat2", fifo_count, 8);

        // Full FIFO with push and pop in the same cycle
        tick(0, 4'h0, 8'h00, 0, 1);
        tick(1, 4'b1111, 8'hE4, 0, 0);
        idle(4, 1);
        chk("full_pushpop_cnt", fifo_count, 8);
        chk("full_pushpop_ovf", overflow, 0);
        idle(10, 1);
        chk("drained", fifo_count, 0);

        // Reset in the middle of a scan
        tick(1, 4'b1111, 8'h00, 0, 0);
        idle(2, 0);
        do_reset();
        tick(1, 4'b0001, 8'h00, 1, 0);
        tick(0, 4'h0, 8'h00, 1, 0);
        chk("post_reset_ts0", ev_if.evt_data, 16'h8000);
        idle(4, 1);

        // Random traffic
        for (int i = 0; i < 600; i++)
            tick($urandom_range(0, 3) == 0, 4'($urandom), 8'($urandom),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
        idle(12, 1);
        chk("final_empty", fifo_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
